// File: rtl/aux_perf_counter_bank.sv
// Bank of event counters for core performance monitoring.
// Snapshot, sticky overflow, saturate/wrap mode and registered read-out.
module aux_perf_counter_bank #(
    parameter int NumCh    = 8,
    parameter int CntBit   = 32,
    parameter int SelBit   = 3,
    parameter int Saturate = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NumCh-1:0]  inc,
    input  logic              clr,
    input  logic              snap,
    input  logic [SelBit-1:0] sel,
    input  logic              use_snap,
    output logic [CntBit-1:0] data_out,
    output logic [NumCh-1:0]  ovf
);

    localparam logic [CntBit-1:0] MaxVal = '1;

    logic [CntBit-1:0] cnt    [NumCh];
    logic [CntBit-1:0] snap_q [NumCh];
    logic              ovf_q  [NumCh];
    logic [CntBit-1:0] rd_val;

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        // Live counter and sticky overflow; clear beats counting.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt[g]   <= '0;
                ovf_q[g] <= 1'b0;
            end else if (clr) begin
                cnt[g]   <= '0;
                ovf_q[g] <= 1'b0;
            end else if (en && inc[g]) begin
                if (cnt[g] == MaxVal) begin
                    ovf_q[g] <= 1'b1;
                    if (Saturate == 0) begin
                        cnt[g] <= '0;
                    end
                end else begin
                    cnt[g] <= cnt[g] + CntBit'(1);
                end
            end
        end

        // Snapshot takes pre-edge counts, so snap+clr is an atomic read-and-reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                snap_q[g] <= '0;
            end else if (snap) begin
                snap_q[g] <= cnt[g];
            end
        end

        assign ovf[g] = ovf_q[g];
    end

    // Read mux; out-of-range selects fall through to zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (sel == SelBit'(i)) begin
                rd_val = use_snap ? snap_q[i] : cnt[i];
            end
        end
    end

    // Registered read-out, refreshed every cycle regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else begin
            data_out <= rd_val;
        end
    end

endmodule

// File: tb/tb_aux_perf_counter_bank.sv
// Directed bench for aux_perf_counter_bank.
// Four instances share stimulus: default, 4-bit saturate, 4-bit wrap, 5-channel.
module tb_aux_perf_counter_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  inc;
    logic        clr;
    logic        snap;
    logic [2:0]  sel;
    logic        use_snap;

    logic [31:0] d_data;
    logic [7:0]  d_ovf;
    logic [3:0]  s4_data;
    logic [7:0]  s4_ovf;
    logic [3:0]  w4_data;
    logic [7:0]  w4_ovf;
    logic [31:0] n5_data;
    logic [4:0]  n5_ovf;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    aux_perf_counter_bank u_d (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .clr(clr),
        .snap(snap), .sel(sel), .use_snap(use_snap),
        .data_out(d_data), .ovf(d_ovf)
    );

    aux_perf_counter_bank #(
        .NumCh(8), .CntBit(4), .SelBit(3), .Saturate(1)
    ) u_s4 (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .clr(clr),
        .snap(snap), .sel(sel), .use_snap(use_snap),
        .data_out(s4_data), .ovf(s4_ovf)
    );

    aux_perf_counter_bank #(
        .NumCh(8), .CntBit(4), .SelBit(3), .Saturate(0)
    ) u_w4 (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .clr(clr),
        .snap(snap), .sel(sel), .use_snap(use_snap),
        .data_out(w4_data), .ovf(w4_ovf)
    );

    aux_perf_counter_bank #(
        .NumCh(5), .CntBit(32), .SelBit(3), .Saturate(1)
    ) u_n5 (
        .clk(clk), .rst(rst), .en(en), .inc(inc[4:0]), .clr(clr),
        .snap(snap), .sel(sel), .use_snap(use_snap),
        .data_out(n5_data), .ovf(n5_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; inc = '0; clr = 1'b0;
        snap = 1'b0; sel = '0; use_snap = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (d_data !== 32'd0)
            $display("FAIL reset_data: got %0d expected 0", d_data);
        else pass_cnt++;
        total_cnt++;
        if (d_ovf !== 8'h00)
            $display("FAIL reset_ovf: got %h expected 00", d_ovf);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_count();
        en = 1'b1; inc = 8'h01;
        repeat (10) tick();
        inc = 8'h00; sel = 3'd0;
        tick();
        total_cnt++;
        if (d_data !== 32'd10)
            $display("FAIL count_ch0: got %0d expected 10", d_data);
        else pass_cnt++;
        for (int s = 1; s < 8; s++) begin
            sel = 3'(s);
            tick();
            total_cnt++;
            if (d_data !== 32'd0)
                $display("FAIL count_ch%0d: got %0d expected 0", s, d_data);
            else pass_cnt++;
        end
        total_cnt++;
        if (d_ovf !== 8'h00)
            $display("FAIL count_ovf: got %h expected 00", d_ovf);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        do_clr();
        en = 1'b0; inc = 8'hFF;
        repeat (5) tick();
        inc = 8'h00;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            total_cnt++;
            if (d_data !== 32'd0)
                $display("FAIL frozen_ch%0d: got %0d expected 0", s, d_data);
            else pass_cnt++;
        end
        en = 1'b1; inc = 8'hFF;
        repeat (3) tick();
        inc = 8'h00;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            total_cnt++;
            if (d_data !== 32'd3)
                $display("FAIL all_ch%0d: got %0d expected 3", s, d_data);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturate_wrap();
        do_clr();
        en = 1'b1; use_snap = 1'b0; inc = 8'h04;
        repeat (17) tick();
        inc = 8'h00; sel = 3'd2;
        tick();
        total_cnt++;
        if (w4_data !== 4'd1)
            $display("FAIL wrap17_cnt: got %0d expected 1", w4_data);
        else pass_cnt++;
        total_cnt++;
        if (w4_ovf !== 8'h04)
            $display("FAIL wrap17_ovf: got %h expected 04", w4_ovf);
        else pass_cnt++;
        total_cnt++;
        if (s4_data !== 4'd15)
            $display("FAIL sat17_cnt: got %0d expected 15", s4_data);
        else pass_cnt++;
        total_cnt++;
        if (d_data !== 32'd17)
            $display("FAIL wide17_cnt: got %0d expected 17", d_data);
        else pass_cnt++;
        inc = 8'h04;
        repeat (3) tick();
        inc = 8'h00;
        tick();
        total_cnt++;
        if (s4_data !== 4'd15)
            $display("FAIL sat20_cnt: got %0d expected 15", s4_data);
        else pass_cnt++;
        total_cnt++;
        if (s4_ovf !== 8'h04)
            $display("FAIL sat20_ovf: got %h expected 04", s4_ovf);
        else pass_cnt++;
        total_cnt++;
        if (w4_data !== 4'd4)
            $display("FAIL wrap20_cnt: got %0d expected 4", w4_data);
        else pass_cnt++;
        total_cnt++;
        if (w4_ovf !== 8'h04)
            $display("FAIL wrap20_ovf: got %h expected 04", w4_ovf);
        else pass_cnt++;
        do_clr();
        tick();
        total_cnt++;
        if (s4_data !== 4'd0 || s4_ovf !== 8'h00)
            $display("FAIL sat_clr: got %0d/%h expected 0/00", s4_data, s4_ovf);
        else pass_cnt++;
        total_cnt++;
        if (w4_data !== 4'd0 || w4_ovf !== 8'h00)
            $display("FAIL wrap_clr: got %0d/%h expected 0/00", w4_data, w4_ovf);
        else pass_cnt++;
    endtask

    task automatic test_snap_clr();
        do_clr();
        en = 1'b1; inc = 8'h02;
        repeat (100) tick();
        snap = 1'b1; clr = 1'b1;
        tick();
        snap = 1'b0; clr = 1'b0; inc = 8'h00;
        use_snap = 1'b1; sel = 3'd1;
        tick();
        total_cnt++;
        if (d_data !== 32'd100)
            $display("FAIL snap_val: got %0d expected 100", d_data);
        else pass_cnt++;
        use_snap = 1'b0;
        tick();
        total_cnt++;
        if (d_data !== 32'd0)
            $display("FAIL snap_live_cleared: got %0d expected 0", d_data);
        else pass_cnt++;
        do_clr();
        use_snap = 1'b1;
        tick();
        total_cnt++;
        if (d_data !== 32'd100)
            $display("FAIL snap_keep_on_clr: got %0d expected 100", d_data);
        else pass_cnt++;
        use_snap = 1'b0;
    endtask

    task automatic test_sel_range();
        do_clr();
        en = 1'b1; inc = 8'hFF;
        repeat (2) tick();
        inc = 8'h00; sel = 3'd6;
        tick();
        total_cnt++;
        if (n5_data !== 32'd0)
            $display("FAIL n5_sel6: got %0d expected 0", n5_data);
        else pass_cnt++;
        total_cnt++;
        if (d_data !== 32'd2)
            $display("FAIL d_sel6: got %0d expected 2", d_data);
        else pass_cnt++;
        sel = 3'd4;
        tick();
        total_cnt++;
        if (n5_data !== 32'd2)
            $display("FAIL n5_sel4: got %0d expected 2", n5_data);
        else pass_cnt++;
        sel = 3'd7;
        tick();
        total_cnt++;
        if (n5_data !== 32'd0)
            $display("FAIL n5_sel7: got %0d expected 0", n5_data);
        else pass_cnt++;
        snap = 1'b1;
        tick();
        snap = 1'b0; use_snap = 1'b1; sel = 3'd6;
        tick();
        total_cnt++;
        if (n5_data !== 32'd0)
            $display("FAIL n5_snap_sel6: got %0d expected 0", n5_data);
        else pass_cnt++;
        sel = 3'd4;
        tick();
        total_cnt++;
        if (n5_data !== 32'd2)
            $display("FAIL n5_snap_sel4: got %0d expected 2", n5_data);
        else pass_cnt++;
        use_snap = 1'b0;
    endtask

    task automatic test_rst_mid();
        en = 1'b1; inc = 8'hFF; sel = 3'd0;
        repeat (20) tick();
        total_cnt++;
        if (s4_ovf !== 8'hFF)
            $display("FAIL pre_rst_ovf: got %h expected ff", s4_ovf);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (d_data !== 32'd0 || s4_ovf !== 8'h00 || w4_ovf !== 8'h00)
            $display("FAIL rst_mid: got %0d/%h/%h expected 0/00/00",
                     d_data, s4_ovf, w4_ovf);
        else pass_cnt++;
        rst = 1'b0; inc = 8'h00;
        tick();
        total_cnt++;
        if (d_data !== 32'd0)
            $display("FAIL rst_live: got %0d expected 0", d_data);
        else pass_cnt++;
        use_snap = 1'b1;
        tick();
        total_cnt++;
        if (d_data !== 32'd0)
            $display("FAIL rst_snap: got %0d expected 0", d_data);
        else pass_cnt++;
        use_snap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_enable();
        test_saturate_wrap();
        test_snap_clr();
        test_sel_range();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
